// File: rtl/exe_stage_pkg.sv
// Shared types and constants for the execute stage.
// Holds ALU command codes, shift types and forwarding selects.
package exe_stage_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      CMD_MOV = 4'b0001,
      CMD_MVN = 4'b1001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000
   } exe_cmd_e;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_e;

   typedef enum logic [1:0] {
      FWD_ID  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10,
      FWD_ID2 = 2'b11
   } fwd_sel_e;

   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic              mem_w_en;
      logic [XLEN-1:0]   alu_res;
      logic [XLEN-1:0]   val_rm;
      logic [3:0]        dest;
   } ex_mem_t;

   function automatic logic [XLEN-1:0] fwd_mux(
      input logic [1:0]      sel,
      input logic [XLEN-1:0] id_val,
      input logic [XLEN-1:0] mem_val,
      input logic [XLEN-1:0] wb_val
   );
      logic [XLEN-1:0] r;
      case (sel)
         FWD_MEM: r = mem_val;
         FWD_WB:  r = wb_val;
         default: r = id_val;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX bundle consumed by the execute stage.
// The ID side drives (master), the EX side reads (slave).
interface exe_stage_if;
   import exe_stage_pkg::*;

   logic [XLEN-1:0] pc_in;
   logic            wb_en_in;
   logic            mem_r_en_in;
   logic            mem_w_en_in;
   logic            b_in;
   logic            s_in;
   logic            imm_in;
   logic            c_in;
   logic [3:0]      exe_cmd_in;
   logic [XLEN-1:0] val_rn_in;
   logic [XLEN-1:0] val_rm_in;
   logic [3:0]      dest_in;
   logic [11:0]     shift_operand_in;
   logic [23:0]     signed_imm_24_in;

   modport master (
      output pc_in, wb_en_in, mem_r_en_in, mem_w_en_in,
      output b_in, s_in, imm_in, c_in, exe_cmd_in,
      output val_rn_in, val_rm_in, dest_in,
      output shift_operand_in, signed_imm_24_in
   );

   modport slave (
      input pc_in, wb_en_in, mem_r_en_in, mem_w_en_in,
      input b_in, s_in, imm_in, c_in, exe_cmd_in,
      input val_rn_in, val_rm_in, dest_in,
      input shift_operand_in, signed_imm_24_in
   );

endinterface

// File: rtl/exe_stage_val2_generator.sv
// Second-operand generator: rotated imm8, 12-bit offset,
// or shifted register.
module val2_generator
   import exe_stage_pkg::*;
(
   input  logic            imm_i,
   input  logic            mem_i,
   input  logic [11:0]     shift_operand_i,
   input  logic [XLEN-1:0] rm_i,
   output logic [XLEN-1:0] val2_o
);

   logic [4:0]        rot_amt;
   logic [4:0]        sh_amt;
   logic [2*XLEN-1:0] imm_dbl;
   logic [2*XLEN-1:0] rm_dbl;
   logic [2*XLEN-1:0] imm_rot;
   logic [2*XLEN-1:0] rm_rot;

   assign rot_amt = {shift_operand_i[11:8], 1'b0};
   assign sh_amt  = shift_operand_i[11:7];
   assign imm_dbl = {24'd0, shift_operand_i[7:0],
                     24'd0, shift_operand_i[7:0]};
   assign rm_dbl  = {rm_i, rm_i};
   // Rotation as a right shift of the doubled word.
   assign imm_rot = imm_dbl >> rot_amt;
   assign rm_rot  = rm_dbl >> sh_amt;

   always_comb begin
      val2_o = rm_i;
      if (imm_i) begin
         val2_o = imm_rot[XLEN-1:0];
      end else if (mem_i) begin
         val2_o = {20'd0, shift_operand_i};
      end else begin
         case (shift_operand_i[6:5])
            SH_LSL:  val2_o = rm_i << sh_amt;
            SH_LSR:  val2_o = rm_i >> sh_amt;
            SH_ASR:  val2_o = $signed(rm_i) >>> sh_amt;
            default: val2_o = rm_rot[XLEN-1:0];
         endcase
      end
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding, Val2, ALU, branch target,
// NZCV status register and EX/MEM pipeline register.
module exe_stage
   import exe_stage_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   exe_stage_if.slave       idex,
   input  logic [1:0]       sel_src1,
   input  logic [1:0]       sel_src2,
   input  logic [WIDTH-1:0] mem_fwd_value,
   input  logic [WIDTH-1:0] wb_fwd_value,
   output logic             br_taken,
   output logic [WIDTH-1:0] br_addr,
   output logic [3:0]       status_out,
   output logic             wb_en_out,
   output logic             mem_r_en_out,
   output logic             mem_w_en_out,
   output logic [WIDTH-1:0] alu_res_out,
   output logic [WIDTH-1:0] val_rm_out,
   output logic [3:0]       dest_out
);

   logic [WIDTH-1:0] a_w;
   logic [WIDTH-1:0] rm_w;
   logic [WIDTH-1:0] b_w;
   logic [WIDTH-1:0] res_w;
   logic [WIDTH:0]   sum_w;
   logic             c_w;
   logic             v_w;
   logic [3:0]       status_d;
   logic [3:0]       status_q;
   ex_mem_t          ex_mem_d;
   ex_mem_t          ex_mem_q;

   assign a_w  = fwd_mux(sel_src1, idex.val_rn_in,
                         mem_fwd_value, wb_fwd_value);
   assign rm_w = fwd_mux(sel_src2, idex.val_rm_in,
                         mem_fwd_value, wb_fwd_value);

   val2_generator u_val2 (
      .imm_i           (idex.imm_in),
      .mem_i           (idex.mem_r_en_in | idex.mem_w_en_in),
      .shift_operand_i (idex.shift_operand_in),
      .rm_i            (rm_w),
      .val2_o          (b_w)
   );

   assign br_taken = idex.b_in;
   assign br_addr  = idex.pc_in +
      {{6{idex.signed_imm_24_in[23]}}, idex.signed_imm_24_in, 2'b00};

   // C/V default to the held flags; only arithmetic overrides them.
   always_comb begin
      res_w = '0;
      sum_w = '0;
      c_w   = status_q[1];
      v_w   = status_q[0];
      case (idex.exe_cmd_in)
         CMD_MOV: res_w = b_w;
         CMD_MVN: res_w = ~b_w;
         CMD_AND: res_w = a_w & b_w;
         CMD_ORR: res_w = a_w | b_w;
         CMD_EOR: res_w = a_w ^ b_w;
         CMD_ADD, CMD_ADC: begin
            sum_w = {1'b0, a_w} + {1'b0, b_w} +
                    {{WIDTH{1'b0}},
                     idex.c_in & (idex.exe_cmd_in == CMD_ADC)};
            res_w = sum_w[WIDTH-1:0];
            c_w   = sum_w[WIDTH];
            v_w   = (a_w[WIDTH-1] == b_w[WIDTH-1]) &&
                    (res_w[WIDTH-1] != a_w[WIDTH-1]);
         end
         CMD_SUB, CMD_SBC: begin
            sum_w = {1'b0, a_w} + {1'b0, ~b_w} +
                    {{WIDTH{1'b0}},
                     (idex.exe_cmd_in == CMD_SUB) | idex.c_in};
            res_w = sum_w[WIDTH-1:0];
            c_w   = sum_w[WIDTH];
            v_w   = (a_w[WIDTH-1] != b_w[WIDTH-1]) &&
                    (res_w[WIDTH-1] != a_w[WIDTH-1]);
         end
         default: res_w = '0;
      endcase
   end

   assign status_d = {res_w[WIDTH-1], res_w == '0, c_w, v_w};

   always_comb begin
      ex_mem_d          = '0;
      ex_mem_d.wb_en    = idex.wb_en_in;
      ex_mem_d.mem_r_en = idex.mem_r_en_in;
      ex_mem_d.mem_w_en = idex.mem_w_en_in;
      ex_mem_d.alu_res  = res_w;
      ex_mem_d.val_rm   = rm_w;
      ex_mem_d.dest     = idex.dest_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_mem_q <= '0;
         status_q <= '0;
      end else if (!freeze) begin
         ex_mem_q <= ex_mem_d;
         if (idex.s_in) begin
            status_q <= status_d;
         end
      end
   end

   assign status_out   = status_q;
   assign wb_en_out    = ex_mem_q.wb_en;
   assign mem_r_en_out = ex_mem_q.mem_r_en;
   assign mem_w_en_out = ex_mem_q.mem_w_en;
   assign alu_res_out  = ex_mem_q.alu_res;
   assign val_rm_out   = ex_mem_q.val_rm;
   assign dest_out     = ex_mem_q.dest;

endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage.
module tb_exe_stage;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic [1:0]  sel_src1;
   logic [1:0]  sel_src2;
   logic [31:0] mem_fwd_value;
   logic [31:0] wb_fwd_value;
   logic        br_taken;
   logic [31:0] br_addr;
   logic [3:0]  status_out;
   logic        wb_en_out;
   logic        mem_r_en_out;
   logic        mem_w_en_out;
   logic [31:0] alu_res_out;
   logic [31:0] val_rm_out;
   logic [3:0]  dest_out;

   int checks = 0;
   int errors = 0;

   exe_stage_if idex ();

   exe_stage #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .freeze        (freeze),
      .idex          (idex.slave),
      .sel_src1      (sel_src1),
      .sel_src2      (sel_src2),
      .mem_fwd_value (mem_fwd_value),
      .wb_fwd_value  (wb_fwd_value),
      .br_taken      (br_taken),
      .br_addr       (br_addr),
      .status_out    (status_out),
      .wb_en_out     (wb_en_out),
      .mem_r_en_out  (mem_r_en_out),
      .mem_w_en_out  (mem_w_en_out),
      .alu_res_out   (alu_res_out),
      .val_rm_out    (val_rm_out),
      .dest_out      (dest_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      idex.pc_in            = '0;
      idex.wb_en_in         = 1'b0;
      idex.mem_r_en_in      = 1'b0;
      idex.mem_w_en_in      = 1'b0;
      idex.b_in             = 1'b0;
      idex.s_in             = 1'b0;
      idex.imm_in           = 1'b0;
      idex.c_in             = 1'b0;
      idex.exe_cmd_in       = 4'b0000;
      idex.val_rn_in        = '0;
      idex.val_rm_in        = '0;
      idex.dest_in          = '0;
      idex.shift_operand_in = '0;
      idex.signed_imm_24_in = '0;
      sel_src1      = 2'b00;
      sel_src2      = 2'b00;
      mem_fwd_value = '0;
      wb_fwd_value  = '0;
   endtask

   task automatic op(input logic [3:0]  cmd,
                     input logic        s,
                     input logic        imm,
                     input logic [31:0] a,
                     input logic [31:0] rm,
                     input logic [11:0] so);
      idle();
      idex.wb_en_in         = 1'b1;
      idex.exe_cmd_in       = cmd;
      idex.s_in             = s;
      idex.imm_in           = imm;
      idex.val_rn_in        = a;
      idex.val_rm_in        = rm;
      idex.shift_operand_in = so;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      freeze = 1'b0;
      idle();
      #12;
      chk("reset_res", alu_res_out, 32'h0);
      chk("reset_status", {28'h0, status_out}, 32'h0);
      chk("reset_wb", {31'h0, wb_en_out}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // ADD overflow into sign bit
      op(4'b0010, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0, 12'h001);
      idex.dest_in = 4'd7;
      step();
      chk("add_res", alu_res_out, 32'h8000_0000);
      chk("add_status", {28'h0, status_out}, 32'h9);
      chk("add_dest", {28'h0, dest_out}, 32'h7);
      chk("add_wb", {31'h0, wb_en_out}, 32'h1);

      op(4'b0100, 1'b1, 1'b0, 32'h5, 32'h5, 12'h000);
      step();
      chk("sub_res", alu_res_out, 32'h0);
      chk("sub_status", {28'h0, status_out}, 32'h6);

      op(4'b0110, 1'b1, 1'b0, 32'hF0, 32'h3C, 12'h000);
      step();
      chk("and_res", alu_res_out, 32'h30);
      chk("and_status", {28'h0, status_out}, 32'h2);

      // Freeze for three edges with s=1
      op(4'b0010, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 12'h001);
      freeze = 1'b1;
      step();
      step();
      step();
      chk("frz_res", alu_res_out, 32'h30);
      chk("frz_status", {28'h0, status_out}, 32'h2);
      freeze = 1'b0;
      step();
      chk("unfrz_res", alu_res_out, 32'h0);
      chk("unfrz_status", {28'h0, status_out}, 32'h6);

      op(4'b0001, 1'b0, 1'b1, 32'h0, 32'h0, 12'h4FF);
      step();
      chk("mov_imm", alu_res_out, 32'hFF00_0000);
      chk("mov_nos_status", {28'h0, status_out}, 32'h6);

      op(4'b0010, 1'b0, 1'b0, 32'h100, 32'h0, 12'hFFF);
      idex.mem_r_en_in = 1'b1;
      step();
      chk("ldr_addr", alu_res_out, 32'h10FF);
      chk("ldr_ren", {31'h0, mem_r_en_out}, 32'h1);

      op(4'b0001, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 12'h240);
      step();
      chk("asr4", alu_res_out, 32'hF800_0000);

      op(4'b0001, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 12'h220);
      step();
      chk("lsr4", alu_res_out, 32'h0800_0000);

      op(4'b0001, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 12'h460);
      step();
      chk("ror8", alu_res_out, 32'h7812_3456);

      op(4'b1001, 1'b0, 1'b0, 32'h0, 32'h0, 12'h000);
      step();
      chk("mvn0", alu_res_out, 32'hFFFF_FFFF);

      op(4'b0100, 1'b0, 1'b0, 32'h99, 32'h77, 12'h000);
      sel_src1      = 2'b01;
      mem_fwd_value = 32'h10;
      sel_src2      = 2'b10;
      wb_fwd_value  = 32'h3;
      step();
      chk("fwd_sub", alu_res_out, 32'hD);
      chk("fwd_rm", val_rm_out, 32'h3);

      op(4'b0011, 1'b0, 1'b0, 32'h1, 32'h2, 12'h000);
      idex.c_in = 1'b1;
      step();
      chk("adc", alu_res_out, 32'h4);

      op(4'b0101, 1'b0, 1'b0, 32'hA, 32'h3, 12'h000);
      idex.c_in = 1'b0;
      step();
      chk("sbc", alu_res_out, 32'h6);

      op(4'b0010, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0, 12'h001);
      step();
      op(4'b1111, 1'b1, 1'b0, 32'h1234, 32'h5678, 12'h000);
      step();
      chk("undef_res", alu_res_out, 32'h0);
      chk("undef_status", {28'h0, status_out}, 32'h5);

      // Store data path via Rm forwarding
      op(4'b0010, 1'b0, 1'b0, 32'h200, 32'h0, 12'h004);
      idex.wb_en_in    = 1'b0;
      idex.mem_w_en_in = 1'b1;
      sel_src2         = 2'b10;
      wb_fwd_value     = 32'hCAFE_F00D;
      step();
      chk("str_addr", alu_res_out, 32'h204);
      chk("str_data", val_rm_out, 32'hCAFE_F00D);
      chk("str_wen", {31'h0, mem_w_en_out}, 32'h1);

      idle();
      idex.pc_in            = 32'h100;
      idex.signed_imm_24_in = 24'hFFFFFE;
      idex.b_in             = 1'b1;
      #1;
      chk("br_taken", {31'h0, br_taken}, 32'h1);
      chk("br_addr", br_addr, 32'hF8);

      // Async reset while frozen, away from any edge
      step();
      freeze = 1'b1;
      op(4'b0001, 1'b1, 1'b1, 32'h0, 32'h0, 12'h0FF);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_frz_res", alu_res_out, 32'h0);
      chk("rst_frz_status", {28'h0, status_out}, 32'h0);
      chk("rst_frz_wen", {31'h0, mem_w_en_out}, 32'h0);
      chk("rst_frz_rm", val_rm_out, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM-subset pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Contents: operand forwarding muxes, Val2 generator, ALU, branch-target adder, the NZCV status register, and the EX/MEM pipeline register.
- Status flags go back to the ID stage's condition check. The branch target goes to IF.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- freeze  in  1  hold EX/MEM register and status register (memory wait)
- pc_in  in  32  PC+4 of the instruction
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, c_in  in  1 each  control bits from ID/EX; c_in is the C flag captured at decode
- exe_cmd_in  in  4  ALU command
- val_rn_in, val_rm_in  in  32 each  register operands
- dest_in  in  4  destination register
- shift_operand_in  in  12  shifter operand
- signed_imm_24_in  in  24  branch offset
- sel_src1, sel_src2  in  2 each  forwarding selects: 00 ID value, 01 mem_fwd_value, 10 wb_fwd_value, 11 same as 00
- mem_fwd_value, wb_fwd_value  in  32 each  forwarded results
- br_taken  out  1  combinational, equals b_in
- br_addr  out  32  combinational, pc_in + (sign_extend(signed_imm_24_in) << 2), modulo 2^32
- status_out  out  4  registered NZCV {N,Z,C,V}
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered
- alu_res_out  out  32  registered ALU result
- val_rm_out  out  32  registered forwarded Rm, used as store data
- dest_out  out  4  registered

Behaviour:
- Reset (async, rst=1): all registered outputs are 0, and status_out = 4'b0000. Reset asserted mid-stream overrides freeze.
- Operands:
  - A = forwarded Rn, selected by sel_src1.
  - Rm' = forwarded Rm, selected by sel_src2. Rm' feeds both the Val2 generator and val_rm_out.
- Val2, in priority order:
  - imm_in=1: zero-extended imm8 = shift_operand[7:0], rotated right by 2*shift_operand[11:8].
  - Else, if mem_r_en_in or mem_w_en_in: zero_extend(shift_operand[11:0]).
  - Else: Rm' shifted by shift_imm = shift_operand[11:7], with type shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - Shift amount 0 passes Rm' unchanged for every type. There is no ARM #32 special case.
- ALU (exe_cmd):
  - 0001 MOV: B.
  - 1001 MVN: ~B.
  - 0010 ADD: A+B.
  - 0011 ADC: A+B+c_in.
  - 0100 SUB: A-B.
  - 0101 SBC: A-B-!c_in.
  - 0110 AND.
  - 0111 ORR.
  - 1000 EOR.
  - Any other code: result 0, flags N/Z computed, C/V preserved.
- Flags:
  - N = res[31]; Z = (res==0).
  - Arithmetic ops: C = carry-out of the 33-bit sum. For SUB/SBC this is the ARM no-borrow convention, so C=1 when no borrow occurs.
  - Add overflow: V = (A[31]==B[31]) && (res[31]!=A[31]).
  - Subtract overflow: V = (A[31]!=B[31]) && (res[31]!=A[31]).
  - Logical, MOV and MVN: C and V are held at their current status-register values.
- Status register: on posedge clk with freeze=0 and s_in=1, it loads the new NZCV. Otherwise it holds. A bubble (all-zero control) never updates it.
- EX/MEM register: on posedge clk with freeze=0, it captures wb_en, mem_r_en, mem_w_en, ALU result, Rm' and dest. With freeze=1, all outputs hold. Latency is 1 cycle from ID/EX outputs to the *_out ports.
- Simultaneous events: freeze=1 with s_in=1 does not update flags. The same instruction updates flags once, on the first unfrozen edge.

Decomposition:
- Shared package holds:
  - exe_cmd codes: MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR.
  - Shift type codes.
  - Forwarding select codes.
- One natural sub-module, val2_generator (combinational). The ALU stays inline.

Test Plan:
- Reset mid-operation: rst=1 while freeze=1 -> all *_out=0 and status_out=0 immediately, without waiting for a clock edge.
- ADD with s=1, A=0x7FFFFFFF, imm=1, shift_operand=0x001 -> next cycle: alu_res_out=0x80000000, status_out=4'b1001.
- SUB with s=1, A=5, Val2 from Rm'=5 with LSL #0 -> alu_res_out=0, status_out=4'b0110. Then AND with s=1 and result nonzero -> status_out=4'b0010 (C held, V held at 0).
- Val2 forms:
  - imm=1, shift_operand=0x4FF, MOV -> alu_res_out=0xFF000000.
  - mem_r_en=1, shift_operand=0xFFF, ADD with A=0x100 -> alu_res_out=0x10FF.
  - ASR #4 of 0x80000000 -> 0xF8000000.
- Forwarding: sel_src1=01 with mem_fwd_value=0x10, sel_src2=10 with wb_fwd_value=0x3, SUB -> alu_res_out=0xD and val_rm_out=0x3.
- Branch and freeze:
  - pc_in=0x100, signed_imm_24=0xFFFFFE, b_in=1 -> br_taken=1 and br_addr=0xF8 in the same cycle.
  - freeze=1 for 3 cycles with s_in=1 -> outputs and status hold; they update on the first edge after freeze deasserts.
